spam_timer: RTL

//  Countdown timer/interrupt peripheral on the SPAM bus, in parallel with the console and LCD devices.

---
 rtl/spam_timer_pkg.sv | 38 +++
 rtl/spam_timer_prescaler.sv | 31 +++
 rtl/spam_timer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/spam_timer_pkg.sv
// Shared constants and types for the SPAM countdown timer.
// Holds the SPAM bus widths used by this block together with the timer
// register selects and CTRL bit positions.
package spam_timer_pkg;

   // SPAM bus field widths (high bit indices)
   localparam int SPAM_DID_HI  = 3;
   localparam int SPAM_ADDR_HI = 7;
   localparam int SPAM_DATA_HI = 31;
   localparam int SPAM_DATA_W  = SPAM_DATA_HI + 1;

   // Register selects, decoded from addr[4:2]
   localparam logic [2:0] TMR_REG_CTRL     = 3'd0;
   localparam logic [2:0] TMR_REG_LOAD     = 3'd1;
   localparam logic [2:0] TMR_REG_COUNT    = 3'd2;
   localparam logic [2:0] TMR_REG_PRESCALE = 3'd3;
   localparam logic [2:0] TMR_REG_STATUS   = 3'd4;
   localparam logic [2:0] TMR_REG_CAPTURE  = 3'd5;

   // CTRL / STATUS bit indices
   localparam int TMR_CTRL_EN        = 0;
   localparam int TMR_CTRL_AUTO      = 1;
   localparam int TMR_CTRL_IRQ_EN    = 2;
   localparam int TMR_STATUS_EXPIRED = 0;

   // CTRL register image; en sits in bit 0
   typedef struct packed {
      logic irq_en;
      logic autoreload;
      logic en;
   } tmr_ctrl_t;

   // Register select field of a SPAM byte address
   function automatic logic [2:0] tmr_sel(input logic [SPAM_ADDR_HI:0] addr);
      return addr[4:2];
   endfunction

endpackage

// File: rtl/spam_timer_prescaler.sv
// Prescaler for the SPAM timer: pcnt runs 0..prescale and emits a one-cycle
// tick when it reaches prescale, then wraps to 0. Held at 0 while disabled.
module spam_timer_prescaler #(
   parameter int PRESC_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr,
   input  logic [PRESC_W-1:0] prescale,
   output logic               tick
);

   logic [PRESC_W-1:0] pcnt;

   // Terminal compare uses >= so that lowering PRESCALE below the running
   // pcnt wraps immediately instead of running through the whole range.
   assign tick = en && (pcnt >= prescale);

   // Prescale counter: hold at 0 when disabled or cleared, otherwise count and wrap
   always_ff @(posedge clk) begin
      if (rst || !en || clr) begin
         pcnt <= '0;
      end else if (pcnt >= prescale) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

endmodule

// File: rtl/spam_timer.sv
// SPAM countdown timer / interrupt peripheral.
// Register file, address decode and one-cycle response pipeline; the
// prescaler lives in spam_timer_prescaler.
// Optional capture input is compiled in with SPAM_TIMER_CAPTURE_EN.
//
// Handshake: there is no ready; a request is accepted in the cycle that
// spamo_valid is high with spamo_did == DEVICE_ID. Exactly one cycle later
// tmr__spami_busy_b is high for one cycle, with read data on
// tmr__spami_data in that same cycle. Both outputs are 0 otherwise so the
// block can be OR-ed onto the shared return. A new request may be accepted
// every cycle.
module spam_timer
   import spam_timer_pkg::*;
#(
   parameter logic [SPAM_DID_HI:0] DEVICE_ID = 4'd3,
   parameter int                   COUNT_W   = 32,
   parameter int                   PRESC_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    spamo_valid,
   input  logic                    spamo_r_nw,
   input  logic [SPAM_DID_HI:0]    spamo_did,
   input  logic [SPAM_ADDR_HI:0]   spamo_addr,
   input  logic [SPAM_DATA_HI:0]   spamo_data,
   output logic                    tmr__spami_busy_b,
   output logic [SPAM_DATA_HI:0]   tmr__spami_data,
   output logic                    tmr_irq
`ifdef SPAM_TIMER_CAPTURE_EN
   ,
   input  logic                    tmr_capture
`endif
);

   // Register state
   tmr_ctrl_t            ctrl;
   logic [COUNT_W-1:0]   load_q;
   logic [COUNT_W-1:0]   count_q;
   logic [PRESC_W-1:0]   prescale_q;
   logic                 expired;
   logic                 irq_q;

   // Response pipeline
   logic                 resp_valid;
   logic [SPAM_DATA_HI:0] resp_data;

   // Decode
   logic       acc;
   logic       rd;
   logic       wr;
   logic [2:0] sel;
   logic       wr_ctrl;
   logic       wr_load;
   logic       wr_count;
   logic       wr_prescale;
   logic       wr_status;
   logic [SPAM_DATA_HI:0] rdata;

   // Timer events
   logic tick;
   logic tick_eff;
   logic expire;
   logic pcnt_clr;

   // Address bits outside the register select carry no meaning here
   logic unused_addr;
   assign unused_addr = ^{spamo_addr[SPAM_ADDR_HI:5], spamo_addr[1:0]};

   // Request accept and per-register write strobes
   always_comb begin
      acc         = spamo_valid && (spamo_did == DEVICE_ID);
      rd          = acc && spamo_r_nw;
      wr          = acc && !spamo_r_nw;
      sel         = tmr_sel(spamo_addr);
      wr_ctrl     = wr && (sel == TMR_REG_CTRL);
      wr_load     = wr && (sel == TMR_REG_LOAD);
      wr_count    = wr && (sel == TMR_REG_COUNT);
      wr_prescale = wr && (sel == TMR_REG_PRESCALE);
      wr_status   = wr && (sel == TMR_REG_STATUS);
   end

   // A software write to COUNT or CTRL owns the counter that cycle, so a
   // coincident tick is discarded rather than deferred.
   always_comb begin
      tick_eff = tick && !(wr_count || wr_ctrl);
      expire   = tick_eff && (count_q == '0);
      pcnt_clr = wr_ctrl && spamo_data[TMR_CTRL_EN] && !ctrl.en;
   end

   spam_timer_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (ctrl.en),
      .clr      (pcnt_clr),
      .prescale (prescale_q),
      .tick     (tick)
   );

`ifdef SPAM_TIMER_CAPTURE_EN
   logic               capture_d;
   logic [COUNT_W-1:0] capture_q;

   // Capture COUNT on a rising edge of tmr_capture
   always_ff @(posedge clk) begin
      if (rst) begin
         capture_d <= 1'b0;
         capture_q <= '0;
      end else begin
         capture_d <= tmr_capture;
         if (tmr_capture && !capture_d) begin
            capture_q <= count_q;
         end
      end
   end
`endif

   // Read mux over the current register values (pre-update view)
   always_comb begin
      rdata = '0;
      case (sel)
         TMR_REG_CTRL:     rdata[2:0]         = ctrl;
         TMR_REG_LOAD:     rdata[COUNT_W-1:0] = load_q;
         TMR_REG_COUNT:    rdata[COUNT_W-1:0] = count_q;
         TMR_REG_PRESCALE: rdata[PRESC_W-1:0] = prescale_q;
         TMR_REG_STATUS:   rdata[TMR_STATUS_EXPIRED] = expired;
`ifdef SPAM_TIMER_CAPTURE_EN
         TMR_REG_CAPTURE:  rdata[COUNT_W-1:0] = capture_q;
`endif
         default:          rdata = '0;
      endcase
   end

   // Response register: one-cycle completion pulse, data only for reads
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         resp_valid <= acc;
         resp_data  <= rd ? rdata : '0;
      end
   end

   // CTRL: software write, or one-shot expiry drops EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl <= '0;
      end else if (wr_ctrl) begin
         ctrl <= tmr_ctrl_t'(spamo_data[2:0]);
      end else if (expire && !ctrl.autoreload) begin
         ctrl.en <= 1'b0;
      end
   end

   // LOAD and PRESCALE are plain software registers
   always_ff @(posedge clk) begin
      if (rst) begin
         load_q     <= '0;
         prescale_q <= '0;
      end else begin
         if (wr_load) begin
            load_q <= spamo_data[COUNT_W-1:0];
         end
         if (wr_prescale) begin
            prescale_q <= spamo_data[PRESC_W-1:0];
         end
      end
   end

   // COUNT: software write wins, otherwise decrement or reload on tick
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (wr_count) begin
         count_q <= spamo_data[COUNT_W-1:0];
      end else if (tick_eff) begin
         if (count_q != '0) begin
            count_q <= count_q - 1'b1;
         end else if (ctrl.autoreload) begin
            count_q <= load_q;
         end
      end
   end

   // EXPIRED: sticky, W1C, a new expiry beats a coincident clear
   always_ff @(posedge clk) begin
      if (rst) begin
         expired <= 1'b0;
      end else if (expire) begin
         expired <= 1'b1;
      end else if (wr_status && spamo_data[TMR_STATUS_EXPIRED]) begin
         expired <= 1'b0;
      end
   end

   // Registered level interrupt
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= expired && ctrl.irq_en;
      end
   end

   assign tmr__spami_busy_b = resp_valid;
   assign tmr__spami_data   = resp_data;
   assign tmr_irq           = irq_q;

endmodule
